// File: rtl/regfile_write_ctrl_if.sv
// Register-bank write-port bundle: two writeback requesters in, one bank write port out.
`default_nettype none

interface regfile_write_ctrl_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_rd;
  logic [XLEN-1:0] b_data;
  logic            busy;
  logic            we;
  logic [AW-1:0]   select_d;
  logic [XLEN-1:0] input_d;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, busy, we, select_d, input_d
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, busy, we, select_d, input_d
  );
endinterface

`default_nettype wire

// File: rtl/regfile_write_ctrl.sv
// ============================================================================
// regfile_write_ctrl
//   Owns the bank write port: zero-sweeps x1..x31 after reset, then arbitrates
//   round-robin between writeback sources A and B, one write per cycle.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_write_ctrl #(
  parameter int XLEN           = 32,
  parameter int AW             = 5,
  parameter int NREGS          = 2**AW,
  parameter int CLEAR_ON_RESET = 1
) (
  input  wire logic           clock,
  input  wire logic           reset,
  regfile_write_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t        c_reset_state = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [AW-1:0] c_last_idx    = AW'(NREGS - 1);
  localparam logic          c_grant_a     = 1'b0;
  localparam logic          c_grant_b     = 1'b1;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_last_grant;
  logic            r_we;
  logic [AW-1:0]   r_select_d;
  logic [XLEN-1:0] r_input_d;

  state_t          w_state_nxt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            w_last_grant_nxt;
  logic            w_we_nxt;
  logic [AW-1:0]   w_select_d_nxt;
  logic [XLEN-1:0] w_input_d_nxt;
  logic            w_a_ready;
  logic            w_b_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= c_reset_state;
      r_cnt        <= AW'(1);
      r_last_grant <= c_grant_b;
      r_we         <= 1'b0;
      r_select_d   <= '0;
      r_input_d    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_we         <= w_we_nxt;
      r_select_d   <= w_select_d_nxt;
      r_input_d    <= w_input_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    w_we_nxt         = 1'b0;
    w_select_d_nxt   = r_select_d;
    w_input_d_nxt    = r_input_d;
    w_a_ready        = 1'b0;
    w_b_ready        = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_we_nxt       = 1'b1;
        w_select_d_nxt = r_cnt;
        w_input_d_nxt  = '0;
        w_cnt_nxt      = r_cnt + AW'(1);
        if (r_cnt == c_last_idx) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Ready ignores the source's own valid, so the two can never both handshake.
        w_a_ready = !bus.b_valid || (r_last_grant == c_grant_b);
        w_b_ready = !bus.a_valid || (r_last_grant == c_grant_a);
        if (bus.a_valid && w_a_ready) begin
          w_we_nxt         = (bus.a_rd != '0);
          w_select_d_nxt   = bus.a_rd;
          w_input_d_nxt    = bus.a_data;
          w_last_grant_nxt = c_grant_a;
        end else if (bus.b_valid && w_b_ready) begin
          w_we_nxt         = (bus.b_rd != '0);
          w_select_d_nxt   = bus.b_rd;
          w_input_d_nxt    = bus.b_data;
          w_last_grant_nxt = c_grant_b;
        end
      end
      default: begin
        w_state_nxt = c_reset_state;
      end
    endcase
  end

  assign bus.busy     = (r_state == ST_INIT);
  assign bus.a_ready  = w_a_ready;
  assign bus.b_ready  = w_b_ready;
  assign bus.we       = r_we;
  assign bus.select_d = r_select_d;
  assign bus.input_d  = r_input_d;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_ctrl.sv
// Directed self-checking bench for regfile_write_ctrl, with a behavioural bank model.
`default_nettype none

module tb_regfile_write_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] bank [0:31];

  regfile_write_ctrl_if #(.XLEN(32), .AW(5)) bus  ();
  regfile_write_ctrl_if #(.XLEN(32), .AW(5)) bus2 ();

  regfile_write_ctrl #(.XLEN(32), .AW(5), .NREGS(32), .CLEAR_ON_RESET(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  regfile_write_ctrl #(.XLEN(32), .AW(5), .NREGS(32), .CLEAR_ON_RESET(0)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bank: x0 hard-wired to zero, others start non-zero so the sweep is visible.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) bank[i] <= (i == 0) ? 32'h0 : 32'hFFFF_FFFF;
    end else if (bus.we && bus.select_d != 5'd0) begin
      bank[bus.select_d] <= bus.input_d;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sweep(input bit chk2);
    for (int i = 1; i <= 31; i++) begin
      @(posedge clock); #1;
      check("sweep_we", {63'd0, bus.we}, 64'd1);
      check("sweep_sel", {59'd0, bus.select_d}, 64'(i));
      check("sweep_data", {32'd0, bus.input_d}, 64'd0);
      check("sweep_busy", {63'd0, bus.busy}, (i < 31) ? 64'd1 : 64'd0);
      check("sweep_a_ready", {63'd0, bus.a_ready}, (i < 31) ? 64'd0 : 64'd1);
      if (chk2 && i == 1) begin
        check("nc_we", {63'd0, bus2.we}, 64'd1);
        check("nc_sel", {59'd0, bus2.select_d}, 64'd3);
        check("nc_data", {32'd0, bus2.input_d}, 64'h1234_5678);
        bus2.a_valid = 1'b0;
      end
      if (chk2) check("nc_busy", {63'd0, bus2.busy}, 64'd0);
      if (chk2 && i == 2) check("nc_we_drop", {63'd0, bus2.we}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    bus2.a_valid = 0; bus2.a_rd = 0; bus2.a_data = 0;
    bus2.b_valid = 0; bus2.b_rd = 0; bus2.b_data = 0;
    reset = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd1);
    check("rst_we", {63'd0, bus.we}, 64'd0);
    check("rst_sel", {59'd0, bus.select_d}, 64'd0);
    check("rst_data", {32'd0, bus.input_d}, 64'd0);
    check("rst_a_ready", {63'd0, bus.a_ready}, 64'd0);
    check("rst_busy_nc", {63'd0, bus2.busy}, 64'd0);
    reset = 1'b0;

    sweep(1'b0);
    @(posedge clock); #1;
    check("post_sweep_we", {63'd0, bus.we}, 64'd0);
    for (int i = 1; i < 32; i++) check("bank_zero", {32'd0, bank[i]}, 64'd0);

    // Tie: first grant after reset goes to A, then alternates.
    for (int k = 0; k < 8; k++) begin
      bus.a_valid = 1; bus.a_rd = 5'd5; bus.a_data = 32'hAAAA_0000 + 32'(k);
      bus.b_valid = 1; bus.b_rd = 5'd6; bus.b_data = 32'hBBBB_0000 + 32'(k);
      #1;
      check("tie_a_ready", {63'd0, bus.a_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
      check("tie_b_ready", {63'd0, bus.b_ready}, (k % 2 == 1) ? 64'd1 : 64'd0);
      @(posedge clock); #1;
      check("tie_we", {63'd0, bus.we}, 64'd1);
      check("tie_sel", {59'd0, bus.select_d}, (k % 2 == 0) ? 64'd5 : 64'd6);
      check("tie_data", {32'd0, bus.input_d},
            (k % 2 == 0) ? {32'd0, 32'hAAAA_0000 + 32'(k)} : {32'd0, 32'hBBBB_0000 + 32'(k)});
    end
    bus.a_valid = 0; bus.b_valid = 0;
    @(posedge clock); #1;
    check("idle_we", {63'd0, bus.we}, 64'd0);
    check("idle_sel_hold", {59'd0, bus.select_d}, 64'd6);
    check("idle_data_hold", {32'd0, bus.input_d}, 64'hBBBB_0007);
    check("x5_final", {32'd0, bank[5]}, 64'hAAAA_0006);
    check("x6_final", {32'd0, bank[6]}, 64'hBBBB_0007);

    // Only B: back-to-back writes to x7.
    for (int k = 1; k <= 4; k++) begin
      bus.b_valid = 1; bus.b_rd = 5'd7; bus.b_data = 32'(k);
      #1;
      check("b_only_ready", {63'd0, bus.b_ready}, 64'd1);
      @(posedge clock); #1;
      check("b_only_we", {63'd0, bus.we}, 64'd1);
      check("b_only_sel", {59'd0, bus.select_d}, 64'd7);
      check("b_only_data", {32'd0, bus.input_d}, 64'(k));
    end
    bus.b_valid = 0;
    @(posedge clock); #1;
    check("x7_final", {32'd0, bank[7]}, 64'd4);

    // A writes x0: handshake happens, no write, grant moves to A.
    bus.a_valid = 1; bus.a_rd = 5'd0; bus.a_data = 32'hDEAD_BEEF;
    #1;
    check("x0_a_ready", {63'd0, bus.a_ready}, 64'd1);
    @(posedge clock); #1;
    check("x0_we", {63'd0, bus.we}, 64'd0);
    bus.a_valid = 1; bus.a_rd = 5'd5; bus.a_data = 32'h0000_1111;
    bus.b_valid = 1; bus.b_rd = 5'd6; bus.b_data = 32'h0000_2222;
    #1;
    check("after_x0_a_ready", {63'd0, bus.a_ready}, 64'd0);
    check("after_x0_b_ready", {63'd0, bus.b_ready}, 64'd1);
    @(posedge clock); #1;
    check("after_x0_we", {63'd0, bus.we}, 64'd1);
    check("after_x0_sel", {59'd0, bus.select_d}, 64'd6);
    check("after_x0_data", {32'd0, bus.input_d}, 64'h2222);
    bus.a_valid = 0; bus.b_valid = 0;
    @(posedge clock); #1;
    check("x0_reads_zero", {32'd0, bank[0]}, 64'd0);

    // Reset in the middle of a fresh sweep.
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    check("mid_sel12", {59'd0, bus.select_d}, 64'd12);
    reset = 1'b1;
    #1;
    check("mid_rst_we", {63'd0, bus.we}, 64'd0);
    check("mid_rst_sel", {59'd0, bus.select_d}, 64'd0);
    check("mid_rst_busy", {63'd0, bus.busy}, 64'd1);
    bus.a_valid = 1; bus.a_rd = 5'd9; bus.a_data = 32'h55;
    bus2.a_valid = 1; bus2.a_rd = 5'd3; bus2.a_data = 32'h1234_5678;
    #1;
    check("nc_a_ready", {63'd0, bus2.a_ready}, 64'd1);
    @(negedge clock);
    reset = 1'b0;
    sweep(1'b1);
    @(posedge clock); #1;
    check("held_a_we", {63'd0, bus.we}, 64'd1);
    check("held_a_sel", {59'd0, bus.select_d}, 64'd9);
    check("held_a_data", {32'd0, bus.input_d}, 64'h55);
    bus.a_valid = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
Controller that owns the single write port of the 32-entry register bank. After reset it sweeps x1..x31 to zero, because the bank itself clears only x0. In normal operation it arbitrates round-robin between two writeback requesters: A (execute/ALU result) and B (load unit). It drives we/select_d/input_d of the bank from registers, one write per cycle maximum.

Parameters:
XLEN, 32, data width of write data
AW, 5, register index width
NREGS, 32, number of architectural registers (2**AW)
CLEAR_ON_RESET, 1, 1 = run zero-sweep after reset; 0 = enter RUN directly

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
a_valid  in  1  source A has a write pending
a_ready  out  1  source A write accepted this cycle when high with a_valid
a_rd  in  AW  source A destination index
a_data  in  XLEN  source A write data
b_valid  in  1  source B has a write pending
b_ready  out  1  source B accept
b_rd  in  AW  source B destination index
b_data  in  XLEN  source B write data
busy  out  1  high while init sweep in progress
we  out  1  bank write enable (registered)
select_d  out  AW  bank write index (registered)
input_d  out  XLEN  bank write data (registered)

Behaviour:
- States: INIT, RUN. 5-bit sweep counter cnt. 1-bit last_grant (0=A, 1=B).
- Reset (async, immediate): state = INIT if CLEAR_ON_RESET else RUN; cnt = 1; last_grant = B; we = 0; select_d = 0; input_d = 0.
- busy = (state==INIT), combinational from state. a_ready = b_ready = 0 in INIT.
- INIT, each edge: we<=1, select_d<=cnt, input_d<=0, cnt<=cnt+1. The edge that issues cnt==NREGS-1 moves to RUN.
  - Results in exactly 31 consecutive we pulses, indices 1..31.
  - busy falls in the same cycle as the last pulse (index 31) is presented.
- RUN ready rules (combinational, independent of own valid):
  - a_ready = !b_valid || last_grant==B
  - b_ready = !a_valid || last_grant==A
  - Never both handshakes in one cycle. Requesters must not make valid depend on ready.
- Handshake = valid && ready, sampled at the rising edge. On handshake from X at edge N:
  - we<=(X_rd!=0), select_d<=X_rd, input_d<=X_data, last_grant<=X.
  - we is high for the single cycle after edge N. The bank commits at edge N+1. The value is readable on the bank ports after edge N+1.
- No handshake in RUN: we<=0. select_d and input_d hold their previous values.
- Index 0: the handshake completes and last_grant updates, but we stays 0, so x0 is never written.
- Tie (both valid): grant alternates A,B,A,B... The first tie after reset goes to A.
- Single active source: accepted every cycle (full throughput, back-to-back).
- Same rd from consecutive grants: writes land in acceptance order; the last write wins.
- Valid without handshake: the requester holds rd/data stable until ready. The controller does not latch inputs without a handshake.
- Reset asserted mid-INIT or mid-RUN: outputs clear asynchronously and the sweep restarts from x1 on release. Any in-flight registered write is dropped.
- The controller provides no forwarding. Hazard logic must treat a register with a handshake at edge N as stale until after edge N+1.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, no requests -> exactly 31 we pulses, select_d=1..31 in order, input_d=0. busy high for those 31 cycles, then low. Readback of x1..x31 = 0.
- RUN, A and B valid every cycle (a_rd=5, a_data=0xAAAA0000+k; b_rd=6, b_data=0xBBBB0000+k) -> grants A,B,A,B… starting with A. One we per cycle, select_d alternating 5,6. Final x5/x6 match the last accepted data.
- Only B valid, 4 back-to-back writes to x7 with 1,2,3,4 -> b_ready=1 each cycle, 4 consecutive we pulses, x7=4 after the last.
- A writes rd=0, data=0xDEADBEEF -> a_ready=1, no we pulse, x0 reads 0. last_grant=A, so a following tie grants B.
- Reset asserted at sweep index 12, released -> sweep restarts at x1, 31 pulses total after release. a_ready stays 0 until busy falls.
- CLEAR_ON_RESET=0, a_valid high, a_rd=3, a_data=0x12345678 in the first cycle after reset -> immediate handshake, busy never high, we pulses next cycle with select_d=3, input_d=0x12345678.
